// File: rtl/mux_pkg.sv
// Shared types, constant helpers and macros for the N:1 select mux and its
// skid-buffered output stage.
`ifndef MUX_PKG_SV
`define MUX_PKG_SV

`define MUX_CH(bus, k, w) bus[(k)*(w) +: (w)]

// Elaboration-time guard: the select port must be able to address every channel.
`define MUX_CHECK_SELW(n, selw) \
  if ((selw) < mux_pkg::clog2(n)) begin : g_selw_check \
    $error("mux_n_pipe: SELW too narrow for N channels"); \
  end

package mux_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result = result + 1;
    return result;
  endfunction

endpackage

`endif

// File: rtl/mux_skid_buf.sv
// Two-register (MAIN + SKID) valid/ready stage. in_ready is decoded from the
// state register alone, so it never combinationally depends on out_ready.
module mux_skid_buf
  import mux_pkg::*;
#(
  parameter int PW = 34
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_payload,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_payload
);

  skid_state_t state, state_next;
  logic [PW-1:0] main_q, skid_q;
  logic load_main, load_skid, move_skid;
  logic accept, emit;

  assign in_ready    = (state != ST_FULL);
  assign out_valid   = (state != ST_EMPTY);
  assign out_payload = main_q;
  assign accept      = in_valid & in_ready;
  assign emit        = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    move_skid  = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          load_main  = 1'b1;
          state_next = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && emit) begin
          load_main = 1'b1;
        end else if (accept) begin
          load_skid  = 1'b1;
          state_next = ST_FULL;
        end else if (emit) begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (emit) begin
          move_skid  = 1'b1;
          state_next = ST_ONE;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  // MAIN only changes on a load or a skid move, so it holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)      main_q <= in_payload;
      else if (move_skid) main_q <= skid_q;
      if (load_skid)      skid_q <= in_payload;
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// Parametrised N:1 word selector with ERR_VAL substitution for out-of-range
// selects, a sticky select-error flag and an optional skid-buffered stage.
module mux_n_pipe
  import mux_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter int               N       = 4,
  parameter int               SELW    = 2,
  parameter int               PIPE    = 1,
  parameter logic [WIDTH-1:0] ERR_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SELW-1:0]      in_sel,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 sel_err,
  input  logic                 clr_err
);

  `MUX_CHECK_SELW(N, SELW)

  logic [WIDTH-1:0] mux_word;
  logic             sel_ok;
  logic             accept;

  always_comb begin
    mux_word = ERR_VAL;
    sel_ok   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (in_sel == SELW'(k)) begin
        mux_word = `MUX_CH(in_data, k, WIDTH);
        sel_ok   = 1'b1;
      end
    end
  end

  assign accept = in_valid & in_ready;

  // A bad-select accept in the same cycle as clr_err must leave the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   sel_err <= 1'b0;
    else if (accept && !sel_ok) sel_err <= 1'b1;
    else if (clr_err)          sel_err <= 1'b0;
  end

  generate
    if (PIPE != 0) begin : g_pipe
      logic [WIDTH+SELW-1:0] stage_out;

      mux_skid_buf #(
        .PW(WIDTH + SELW)
      ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_payload  ({mux_word, in_sel}),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_payload (stage_out)
      );

      assign out_data = stage_out[WIDTH+SELW-1:SELW];
      assign out_sel  = stage_out[SELW-1:0];
    end else begin : g_comb
      assign out_valid = in_valid;
      assign in_ready  = out_ready;
      assign out_data  = mux_word;
      assign out_sel   = in_sel;
    end
  endgenerate

endmodule

// File: tb/tb_mux_n_pipe.sv
// Scoreboard bench for mux_n_pipe: a 4-channel and a 3-channel pipelined instance
// share stimulus; a combinational instance is checked directly.
module tb_mux_n_pipe;

  localparam logic [31:0] ERR3 = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic rst, in_valid, out_ready, clr_err;
  logic [1:0]   in_sel;
  logic [127:0] in_data;

  logic rdy4, ov4, err4;
  logic [31:0] od4;
  logic [1:0]  os4;
  logic rdy3, ov3, err3;
  logic [31:0] od3;
  logic [1:0]  os3;
  logic rdy0, ov0, err0;
  logic [31:0] od0;
  logic [1:0]  os0;

  logic [33:0] q4[$];
  logic [33:0] q3[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_n_pipe #(.WIDTH(32), .N(4), .SELW(2), .PIPE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .in_sel(in_sel),
    .in_data(in_data), .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
    .out_sel(os4), .sel_err(err4), .clr_err(clr_err)
  );

  mux_n_pipe #(.WIDTH(32), .N(3), .SELW(2), .PIPE(1), .ERR_VAL(ERR3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy3), .in_sel(in_sel),
    .in_data(in_data[95:0]), .out_valid(ov3), .out_ready(out_ready), .out_data(od3),
    .out_sel(os3), .sel_err(err3), .clr_err(clr_err)
  );

  mux_n_pipe #(.WIDTH(32), .N(4), .SELW(2), .PIPE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_sel(in_sel),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .out_sel(os0), .sel_err(err0), .clr_err(clr_err)
  );

  task automatic checkOutput(input string name, input logic [33:0] actual,
                             input logic [33:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of input; pushes expected words when the pipelined stages accept.
  task automatic applyStimulus(input logic v, input logic [1:0] s, output bit acc);
    logic [31:0] word;
    in_valid = v;
    in_sel   = s;
    acc      = v && rdy4;
    if (acc) begin
      word = in_data[s*32 +: 32];
      q4.push_back({word, s});
      q3.push_back({(s < 2'd3) ? word : ERR3, s});
    end
  endtask

  task automatic sendWord(input logic [1:0] s);
    bit acc;
    int waited;
    waited = 0;
    do begin
      applyStimulus(1'b1, s, acc);
      @(posedge clk);
      #1;
      waited++;
    end while (!acc && waited < 50);
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL send_timeout: in_ready stayed 0 for %0d cycles", waited);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sel   = 'x;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare every presented word with the queue head; pop only on emit.
  always @(negedge clk) begin
    if (!rst && ov4) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL out4_unexpected: got 0x%0h, expected no word", {od4, os4});
      end else begin
        checkOutput("out4", {od4, os4}, q4[0]);
        if (out_ready) void'(q4.pop_front());
      end
    end
    if (!rst && ov3) begin
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL out3_unexpected: got 0x%0h, expected no word", {od3, os3});
      end else begin
        checkOutput("out3", {od3, os3}, q3[0]);
        if (out_ready) void'(q3.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit acc;
    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = 1'b1; clr_err = 1'b0;
    #12;
    checkOutput("rst_out_valid", 34'(ov4), 34'd0);
    checkOutput("rst_out_word", {od4, os4}, 34'd0);
    checkOutput("rst_sel_err", 34'({err4, err3, err0}), 34'd0);
    checkOutput("rst_in_ready", 34'({rdy4, rdy3}), 34'b11);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] select sweep");
    in_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    for (int s = 0; s < 4; s++) begin
      checkOutput("sweep_in_ready", 34'(rdy4), 34'd1);
      sendWord(2'(s));
    end
    idle(3);

    $display("[TB] back-pressure");
    fork
      begin
        sendWord(2'd1);
        sendWord(2'd2);
        sendWord(2'd3);
      end
      begin
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("bp_in_ready_drop", 34'(rdy4), 34'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    idle(4);

    $display("[TB] bad select");
    in_data = {32'hA4A4A4A4, 32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1};
    sendWord(2'd3);
    checkOutput("sel_err_set", 34'(err3), 34'd1);
    checkOutput("sel_err_n4_clear", 34'(err4), 34'd0);
    checkOutput("err_val_out", {od3, os3}, {ERR3, 2'd3});
    idle(1);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    checkOutput("sel_err_clr", 34'(err3), 34'd0);
    clr_err = 1'b1;
    sendWord(2'd3);
    clr_err = 1'b0;
    checkOutput("sel_err_set_wins", 34'(err3), 34'd1);
    idle(3);

    $display("[TB] reset while full");
    out_ready = 1'b0;
    sendWord(2'd0);
    sendWord(2'd1);
    in_valid = 1'b0;
    checkOutput("full_in_ready", 34'(rdy4), 34'd0);
    #2 rst = 1'b1;
    q4.delete();
    q3.delete();
    #1;
    checkOutput("midrst_out_valid", 34'(ov4), 34'd0);
    checkOutput("midrst_in_ready", 34'(rdy4), 34'd1);
    checkOutput("midrst_out_word", {od4, os4}, 34'd0);
    @(negedge clk) rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    sendWord(2'd2);
    checkOutput("post_rst_latency", {ov4, od4, os4}, {1'b1, 32'hA3A3A3A3, 2'd2});
    idle(3);

    $display("[TB] combinational instance");
    in_data = {32'hD4D4D4D4, 32'hC3C3C3C3, 32'hB2B2B2B2, 32'hE1E1E1E1};
    for (int i = 0; i < 4; i++) begin
      out_ready = i[0];
      applyStimulus(1'b1, 2'(i), acc);
      #1;
      checkOutput("pipe0_in_ready", 34'(rdy0), 34'(i[0]));
      checkOutput("pipe0_out", {ov0, od0, os0}, {1'b1, in_data[i*32 +: 32], 2'(i)});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    idle(4);

    $display("[TB] random traffic");
    for (int n = 0; n < 1500; n++) begin
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), acc);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    idle(6);
    checkOutput("drain_q4", 34'(q4.size()), 34'd0);
    checkOutput("drain_q3", 34'(q3.size()), 34'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
